// File: rtl/rx_stream_arbiter_if.sv
// rx_stream_arbiter_if
//   Bundle of the upstream receiver handshakes and the downstream output
//   stage shared by rx_stream_arbiter and its environment.
//   Signals:
//     s_data     NUM_CH*DATA_W  channel i word at [i*DATA_W +: DATA_W]
//     s_valid    NUM_CH         per-channel word valid
//     s_ready    NUM_CH         per-channel accept (driven by the arbiter)
//     ch_enable  NUM_CH         1 = channel may be granted
//     m_data     DATA_W         forwarded word
//     m_id       ID_W           source channel of m_data
//     m_last     1              final word of a full-length burst
//     m_valid    1              output word valid
//     m_ready    1              downstream accept
//   Modports: slave = arbiter side, master = receivers + sink side.
interface rx_stream_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH-1:0]        s_valid;
  logic [NUM_CH-1:0]        s_ready;
  logic [NUM_CH-1:0]        ch_enable;
  logic [DATA_W-1:0]        m_data;
  logic [ID_W-1:0]          m_id;
  logic                     m_last;
  logic                     m_valid;
  logic                     m_ready;

  modport slave (
    input  s_data, s_valid, ch_enable, m_ready,
    output s_ready, m_data, m_id, m_last, m_valid
  );

  modport master (
    output s_data, s_valid, ch_enable, m_ready,
    input  s_ready, m_data, m_id, m_last, m_valid
  );
endinterface

// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter
//   Round-robin arbiter that shares one downstream sink among NUM_CH receiver
//   streams. One enabled channel is granted at a time for at most MAX_BURST
//   words; each word goes through a single registered output stage tagged
//   with its source channel id. A grant costs one idle arbitration cycle.
//   Ports:
//     aclk        rising-edge system clock
//     areset      synchronous, active-high reset
//     bus         rx_stream_arbiter_if.slave (receiver and sink handshakes)
//     word_count  words accepted downstream, wraps modulo 2^CNT_W
module rx_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  rx_stream_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]     word_count
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   gnt_q;
  logic [BC_W-1:0]   burstCnt_q;
  logic [DATA_W-1:0] mData_q;
  logic [ID_W-1:0]   mId_q;
  logic              mLast_q;
  logic              mValid_q;
  logic [CNT_W-1:0]  wordCount_q;

  logic              loadEn;
  logic [NUM_CH-1:0] reqMask;
  logic              reqAny;
  logic [ID_W-1:0]   pick;
  int                scanIdx;
  logic              gntValid;
  logic              gntEnable;
  logic [DATA_W-1:0] gntData;
  logic [NUM_CH-1:0] sReady;
  logic              xfer;
  logic              lastBeat;
  logic              releaseGrant;
  logic [ID_W-1:0]   ptr_d;

  // Grant-side decode. The round-robin scan walks offsets from the highest
  // down to zero so the channel closest to ptr (offset 0) wins last.
  // s_ready is only ever raised for the granted channel, and only when the
  // output stage can take a word and the channel is still enabled, so a
  // disabled channel keeps its word upstream.
  always_comb begin
    loadEn   = !mValid_q || bus.m_ready;
    reqMask  = bus.s_valid & bus.ch_enable;
    reqAny   = |reqMask;
    pick     = '0;
    scanIdx  = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scanIdx = (int'(ptr_q) + i) % NUM_CH;
      if (reqMask[scanIdx]) begin
        pick = ID_W'(scanIdx);
      end
    end

    gntValid  = bus.s_valid[gnt_q];
    gntEnable = bus.ch_enable[gnt_q];
    gntData   = bus.s_data[int'(gnt_q) * DATA_W +: DATA_W];

    sReady = '0;
    if (state_q == GRANT) begin
      sReady[gnt_q] = loadEn && gntEnable;
    end

    xfer     = gntValid && sReady[gnt_q];
    lastBeat = (burstCnt_q == LAST_BEAT);

    // Backpressure alone never releases: with loadEn low only a dropped
    // enable can end the grant.
    releaseGrant = (xfer && lastBeat) || (!gntValid && loadEn) || !gntEnable;

    ptr_d = (int'(gnt_q) == NUM_CH - 1) ? '0 : gnt_q + ID_W'(1);
  end

  // Arbitration FSM, burst counter, output stage and word counter. A drain
  // and a load in the same cycle both happen, which keeps full throughput
  // inside a burst; the output registers only change on a load, so they are
  // stable while the sink stalls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      burstCnt_q  <= '0;
      mData_q     <= '0;
      mId_q       <= '0;
      mLast_q     <= 1'b0;
      mValid_q    <= 1'b0;
      wordCount_q <= '0;
    end else begin
      if (mValid_q && bus.m_ready) begin
        wordCount_q <= wordCount_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (reqAny) begin
            gnt_q      <= pick;
            burstCnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            burstCnt_q <= burstCnt_q + BC_W'(1);
          end
          if (releaseGrant) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (xfer) begin
        mData_q  <= gntData;
        mId_q    <= gnt_q;
        mLast_q  <= lastBeat;
        mValid_q <= 1'b1;
      end else if (mValid_q && bus.m_ready) begin
        mValid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready = sReady;
  assign bus.m_data  = mData_q;
  assign bus.m_id    = mId_q;
  assign bus.m_last  = mLast_q;
  assign bus.m_valid = mValid_q;
  assign word_count  = wordCount_q;
endmodule
